// File: rtl/pulse_shaper_soc_eoc_n.sv
// Converter handshake sequencer: pulses soc, waits for eoc, then drives out high
// for exactly the number of cycles returned on numero, with a per-phase timeout.
module pulse_shaper_soc_eoc_n #(
  parameter int W       = 8,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         cont,
  output logic         soc,
  input  logic         eoc,
  input  logic [W-1:0] numero,
  output logic         out,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOC_HI,
    S_WAIT_EOC,
    S_PULSE,
    S_DONE,
    S_ERR
  } state_t;

  // Last count value of a waiting phase; reaching it without the exit condition
  // means this cycle is the TIMEOUT-th cycle spent in the phase.
  localparam logic [TW:0] TMO_LAST = (TW+1)'(TIMEOUT) - (TW+1)'(1);

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_cnt;
  logic [TW-1:0] r_tmo;
  logic          w_tmo_hit;

  assign w_tmo_hit = (TIMEOUT != 0) && ({1'b0, r_tmo} == TMO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    soc          = 1'b0;
    out          = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start || cont) begin
          w_state_next = S_SOC_HI;
        end
      end
      S_SOC_HI: begin
        soc = 1'b1;
        // Exit condition is tested first so it wins over a simultaneous timeout.
        if (!eoc) begin
          w_state_next = S_WAIT_EOC;
        end else if (w_tmo_hit) begin
          w_state_next = S_ERR;
        end
      end
      S_WAIT_EOC: begin
        if (eoc) begin
          w_state_next = (numero == '0) ? S_DONE : S_PULSE;
        end else if (w_tmo_hit) begin
          w_state_next = S_ERR;
        end
      end
      S_PULSE: begin
        out = 1'b1;
        if (r_cnt == W'(1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = cont ? S_SOC_HI : S_IDLE;
      end
      S_ERR: begin
        err          = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Pulse length counter: loaded from numero only on the eoc edge that leaves WAIT_EOC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_WAIT_EOC && eoc) begin
      r_cnt <= numero;
    end else if (r_state == S_PULSE) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Timeout counter restarts on every state change, so each waiting phase starts at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (w_state_next != r_state) begin
      r_tmo <= '0;
    end else if (r_state == S_SOC_HI || r_state == S_WAIT_EOC) begin
      r_tmo <= r_tmo + TW'(1);
    end
  end

endmodule

// File: tb/tb_pulse_shaper_soc_eoc_n.sv
// Self-checking bench for pulse_shaper_soc_eoc_n: a converter model drives the
// handshake and a scoreboard checks every done/err strobe against queued results.
module tb_pulse_shaper_soc_eoc_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic       soc;
  logic       eoc;
  logic [7:0] numero;
  logic       out;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;
  int idle_cnt = 0;
  int run      = 0;

  typedef struct {
    bit is_err;
    int len;
  } exp_t;

  exp_t sb[$];

  pulse_shaper_soc_eoc_n #(
    .W      (8),
    .TIMEOUT(4),
    .TW     (8)
  ) dut (
    .clock (clk),
    .reset (rst),
    .start (start),
    .cont  (cont),
    .soc   (soc),
    .eoc   (eoc),
    .numero(numero),
    .out   (out),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Scoreboard monitor: measures out-high run length and matches each strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
      end else begin
        if (!busy) idle_cnt++;
        if (out) run++;
        if (done || err) begin
          n_checks++;
          if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: done=%0b err=%0b run=%0d, required no strobe", done, err, run);
          end else begin
            e = sb.pop_front();
            if (err !== e.is_err || (!err && run !== e.len))
              $display("FAIL sb_result: err=%0b run=%0d, required err=%0b run=%0d", err, run, e.is_err, e.len);
            else begin
              n_pass++;
              $display("txn: %s run=%0d at %0t", err ? "err" : "done", run, $time);
            end
          end
          run = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Converter model: eoc drops in soc's 2nd cycle, rises after 3 WAIT_EOC cycles.
  task automatic convert(input logic [7:0] n, input logic [7:0] nchg);
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = soc;
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL conv_soc_start: soc=0, required 1 within 40 cycles");
      return;
    end
    n_pass++;
    @(posedge clk); #1 eoc = 1'b0;
    @(negedge clk);
    n_checks++;
    if (soc !== 1'b1) $display("FAIL conv_soc_cycle2: soc=%0b, required 1", soc);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({soc, busy} !== 2'b01) $display("FAIL conv_wait: soc=%0b busy=%0b, required soc=0 busy=1", soc, busy);
    else n_pass++;
    @(posedge clk);
    @(posedge clk); #1 eoc = 1'b1; numero = n;
    e.is_err = 1'b0;
    e.len    = int'(n);
    sb.push_back(e);
    @(posedge clk); #1 numero = nchg;
  endtask

  task automatic wait_idle(input int budget);
    bit idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    n_checks++;
    if (!idle) $display("FAIL wait_idle: busy=1, required 0 within %0d cycles", budget);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cont = 1'b0; eoc = 1'b1; numero = 8'd0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({soc, out, busy, done, err} !== 5'b0)
      $display("FAIL reset_outputs: soc/out/busy/done/err=%05b, required 00000", {soc, out, busy, done, err});
    else n_pass++;
    @(negedge clk); #2 rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_wait: busy=%0b, required 0 before next edge", busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, soc} !== 2'b11) $display("FAIL reset_first_edge: busy=%0b soc=%0b, required 1 1", busy, soc);
    else n_pass++;
    start = 1'b0;
    convert(8'd2, 8'd9);
    wait_idle(20);
  endtask

  task automatic test_single_shot();
    pulse_start();
    convert(8'd5, 8'd0);
    wait_idle(20);
  endtask

  task automatic test_zero_length();
    pulse_start();
    convert(8'd0, 8'd7);
    @(negedge clk);
    n_checks++;
    if ({done, out} !== 2'b10) $display("FAIL zero_done: done=%0b out=%0b, required 1 0", done, out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL zero_idle: busy=%0b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    pulse_start();
    convert(8'd4, 8'd4);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL start_ignored_%0d: busy=%0b, required 0", i, busy);
      else n_pass++;
    end
  endtask

  task automatic test_continuous();
    int idle0;
    @(posedge clk); #1 cont = 1'b1;
    convert(8'd3, 8'd3);
    idle0 = idle_cnt;
    convert(8'd3, 8'd3);
    convert(8'd3, 8'd3);
    cont = 1'b0;
    n_checks++;
    if (idle_cnt !== idle0) $display("FAIL cont_no_idle: idle cycles=%0d, required 0", idle_cnt - idle0);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) $display("FAIL cont_last_done: done=%0b, required 1", done);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL cont_stop_idle: busy=%0b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int   socn = 0;
    bit   got  = 1'b0;
    exp_t e;
    pulse_start();
    e.is_err = 1'b1;
    e.len    = 0;
    sb.push_back(e);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (err) got = 1'b1;
      else if (soc) socn++;
    end
    n_checks++;
    if (!got || socn !== 4) $display("FAIL timeout_soc: err seen=%0b soc cycles=%0d, required 1 and 4", got, socn);
    else n_pass++;
    n_checks++;
    if ({soc, out} !== 2'b00) $display("FAIL timeout_err_outs: soc=%0b out=%0b, required 0 0", soc, out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL timeout_idle: busy=%0b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_max_value();
    pulse_start();
    convert(8'd255, 8'd1);
    wait_idle(300);
  endtask

  task automatic test_reset_mid_pulse();
    bit bad = 1'b0;
    pulse_start();
    convert(8'd10, 8'd10);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({out, busy, done, soc, err} !== 5'b0)
      $display("FAIL rst_async: out/busy/done/soc/err=%05b, required 00000", {out, busy, done, soc, err});
    else n_pass++;
    sb.delete();
    @(negedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy || out) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL rst_no_done: activity after reset, required done=busy=out=0");
    else n_pass++;
    pulse_start();
    convert(8'd4, 8'd0);
    wait_idle(20);
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_zero_length();
    test_start_ignored();
    test_continuous();
    test_timeout();
    test_max_value();
    test_reset_mid_pulse();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() !== 0) $display("FAIL sb_drain: pending=%0d, required 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
